// File: rtl/can_frame_sequencer.sv
// rtl/can_frame_sequencer.sv - clocked Ethernet-to-CAN word sequencer with shadowed group commit
module can_frame_sequencer #(
    parameter int unsigned ID_A        = 513,
    parameter int unsigned ID_B        = 514,
    parameter int unsigned ID_C        = 515,
    parameter int unsigned ID_D        = 520,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned RST_DATA3   = 100,
    parameter int unsigned RST_DATA7   = 175
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [15:0] byte_from_eth,
    output logic [15:0] data1,
    output logic [15:0] data2,
    output logic [15:0] data3,
    output logic [15:0] data4,
    output logic [15:0] data5,
    output logic [15:0] data6,
    output logic [15:0] data7,
    output logic        upd_a,
    output logic        upd_b,
    output logic        upd_c,
    output logic        err_seq,
    output logic        err_tmo,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, A1, A2, A3, B1, B2, B3, C1, D1
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync2, edge_q, stb, act;
    logic [15:0]   word_q;
    logic [11:0]   sh0, sh1;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    logic [1:0]    tag;
    logic [11:0]   pay;
    logic          is_hdr;
    state_t        hdr_state;
    logic          ld0, ld1, clr_sh, com_a, com_b, com_c, seq_e, tmo_e;

    assign stb     = sync2 & ~edge_q;
    assign tag     = word_q[13:12];
    assign pay     = word_q[11:0];
    assign busy    = (state != IDLE);
    // A strobe clears the counter, so it can never race the timeout.
    assign tmo_hit = busy && !stb && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        is_hdr    = 1'b1;
        hdr_state = IDLE;
        if (word_q == 16'(ID_A))      hdr_state = A1;
        else if (word_q == 16'(ID_B)) hdr_state = B1;
        else if (word_q == 16'(ID_C)) hdr_state = C1;
        else if (word_q == 16'(ID_D)) hdr_state = D1;
        else                          is_hdr    = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            edge_q <= 1'b0;
            act    <= 1'b0;
            word_q <= '0;
        end else begin
            sync1  <= cs;
            sync2  <= sync1;
            edge_q <= sync2;
            act    <= stb;
            if (stb)
                word_q <= byte_from_eth;
        end
    end

    always_comb begin
        state_n = state;
        ld0     = 1'b0;
        ld1     = 1'b0;
        clr_sh  = 1'b0;
        com_a   = 1'b0;
        com_b   = 1'b0;
        com_c   = 1'b0;
        seq_e   = 1'b0;
        tmo_e   = 1'b0;
        if (tmo_hit) begin
            state_n = IDLE;
            clr_sh  = 1'b1;
            tmo_e   = 1'b1;
        end else if (act) begin
            case (state)
                IDLE: if (is_hdr) state_n = hdr_state;
                D1:   state_n = IDLE;
                default: begin
                    if (is_hdr) begin
                        seq_e   = 1'b1;
                        clr_sh  = 1'b1;
                        state_n = hdr_state;
                    end else begin
                        state_n = IDLE;
                        case (state)
                            C1: com_c = 1'b1;
                            A1, B1: begin
                                if (tag == 2'd1) begin
                                    ld0     = 1'b1;
                                    state_n = (state == A1) ? A2 : B2;
                                end
                            end
                            A2, B2: begin
                                if (tag == 2'd2) begin
                                    ld1     = 1'b1;
                                    state_n = (state == A2) ? A3 : B3;
                                end
                            end
                            A3: com_a = (tag == 2'd3);
                            B3: com_b = (tag == 2'd3);
                            default: ;
                        endcase
                        if ((state != C1) && (state_n == IDLE) && !com_a && !com_b) begin
                            seq_e  = 1'b1;
                            clr_sh = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            sh0     <= '0;
            sh1     <= '0;
        end else begin
            state <= state_n;
            if (stb || !busy)
                tmo_cnt <= '0;
            else if (!tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (clr_sh) begin
                sh0 <= '0;
                sh1 <= '0;
            end else begin
                if (ld0) sh0 <= pay;
                if (ld1) sh1 <= pay;
            end
        end
    end

    // Data registers move only on a full commit; partial frames stay hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data1   <= '0;
            data2   <= '0;
            data3   <= 16'(RST_DATA3);
            data4   <= '0;
            data5   <= '0;
            data6   <= '0;
            data7   <= 16'(RST_DATA7);
            upd_a   <= 1'b0;
            upd_b   <= 1'b0;
            upd_c   <= 1'b0;
            err_seq <= 1'b0;
            err_tmo <= 1'b0;
            err_cnt <= '0;
        end else begin
            upd_a   <= com_a;
            upd_b   <= com_b;
            upd_c   <= com_c;
            err_seq <= seq_e;
            err_tmo <= tmo_e;
            if (com_a) begin
                data1 <= {4'h0, sh0};
                data2 <= {4'h0, sh1};
                data3 <= {4'h0, pay};
            end
            if (com_b) begin
                data4 <= {4'h0, sh0};
                data5 <= {4'h0, sh1};
                data6 <= {4'h0, pay};
            end
            if (com_c)
                data7 <= word_q;
            if ((seq_e || tmo_e) && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_can_frame_sequencer.sv
// tb/tb_can_frame_sequencer.sv - table-driven bench for can_frame_sequencer
module tb_can_frame_sequencer;

    localparam int TMO = 50000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic [15:0] byte_from_eth = '0;
    logic [15:0] data1, data2, data3, data4, data5, data6, data7;
    logic        upd_a, upd_b, upd_c, err_seq, err_tmo, busy;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_s = 0, cnt_t = 0;

    can_frame_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .cs(cs), .byte_from_eth(byte_from_eth),
        .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .data5(data5), .data6(data6), .data7(data7),
        .upd_a(upd_a), .upd_b(upd_b), .upd_c(upd_c),
        .err_seq(err_seq), .err_tmo(err_tmo), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (upd_a)   cnt_a <= cnt_a + 1;
            if (upd_b)   cnt_b <= cnt_b + 1;
            if (upd_c)   cnt_c <= cnt_c + 1;
            if (err_seq) cnt_s <= cnt_s + 1;
            if (err_tmo) cnt_t <= cnt_t + 1;
        end
    end

    typedef struct {
        logic [15:0] word;
        logic [15:0] d1, d2, d3, d4, d5, d6, d7;
        logic [7:0]  ec;
        logic        bz;
        int          pa, pb, pc, ps;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        @(negedge clk) byte_from_eth = w;
        @(negedge clk) cs = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_data(input string tagname, input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] e3, input logic [15:0] e7, input logic [7:0] ec);
        check({tagname, ".data1"}, 32'(data1), 32'(e1));
        check({tagname, ".data2"}, 32'(data2), 32'(e2));
        check({tagname, ".data3"}, 32'(data3), 32'(e3));
        check({tagname, ".data7"}, 32'(data7), 32'(e7));
        check({tagname, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    endtask

    initial begin
        int sa, sb, sc, ss, st, n;
        vecs[0]  = '{16'd513,  16'h000, 16'h000, 16'd100, 16'h0, 16'h0, 16'h0, 16'd175, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[1]  = '{16'h1ABC, 16'h000, 16'h000, 16'd100, 16'h0, 16'h0, 16'h0, 16'd175, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[2]  = '{16'h2123, 16'h000, 16'h000, 16'd100, 16'h0, 16'h0, 16'h0, 16'd175, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[3]  = '{16'h3456, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'd175, 8'd0, 1'b0, 1, 0, 0, 0};
        vecs[4]  = '{16'h5000, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'd175, 8'd0, 1'b0, 0, 0, 0, 0};
        vecs[5]  = '{16'd515,  16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'd175, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[6]  = '{16'hBEEF, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd0, 1'b0, 0, 0, 1, 0};
        vecs[7]  = '{16'd520,  16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[8]  = '{16'h1234, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd0, 1'b0, 0, 0, 0, 0};
        vecs[9]  = '{16'd514,  16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[10] = '{16'h1011, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd0, 1'b1, 0, 0, 0, 0};
        vecs[11] = '{16'h3033, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd1, 1'b0, 0, 0, 0, 1};
        vecs[12] = '{16'd513,  16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd1, 1'b1, 0, 0, 0, 0};
        vecs[13] = '{16'h1001, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd1, 1'b1, 0, 0, 0, 0};
        vecs[14] = '{16'd514,  16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd2, 1'b1, 0, 0, 0, 1};
        vecs[15] = '{16'h1004, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd2, 1'b1, 0, 0, 0, 0};
        vecs[16] = '{16'h2005, 16'hABC, 16'h123, 16'h456, 16'h0, 16'h0, 16'h0, 16'hBEEF, 8'd2, 1'b1, 0, 0, 0, 0};
        vecs[17] = '{16'h3006, 16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd2, 1'b0, 0, 1, 0, 0};
        vecs[18] = '{16'd513,  16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd2, 1'b1, 0, 0, 0, 0};
        vecs[19] = '{16'h0001, 16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd3, 1'b0, 0, 0, 0, 1};
        vecs[20] = '{16'd515,  16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd3, 1'b1, 0, 0, 0, 0};
        vecs[21] = '{16'd513,  16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b1, 0, 0, 0, 1};
        vecs[22] = '{16'h1111, 16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b1, 0, 0, 0, 0};
        vecs[23] = '{16'h2222, 16'hABC, 16'h123, 16'h456, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b1, 0, 0, 0, 0};
        vecs[24] = '{16'h3333, 16'h111, 16'h222, 16'h333, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b0, 1, 0, 0, 0};
        vecs[25] = '{16'd520,  16'h111, 16'h222, 16'h333, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b1, 0, 0, 0, 0};
        vecs[26] = '{16'd513,  16'h111, 16'h222, 16'h333, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b0, 0, 0, 0, 0};
        vecs[27] = '{16'h1777, 16'h111, 16'h222, 16'h333, 16'h4, 16'h5, 16'h6, 16'hBEEF, 8'd4, 1'b0, 0, 0, 0, 0};

        // Reset state while rst is held
        repeat (3) @(negedge clk);
        check_data("reset", 16'h0, 16'h0, 16'd100, 16'd175, 8'd0);
        check("reset.data4", 32'(data4), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.pulses", 32'({upd_a, upd_b, upd_c, err_seq, err_tmo}), 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            sa = cnt_a; sb = cnt_b; sc = cnt_c; ss = cnt_s;
            send_word(vecs[i].word);
            check($sformatf("v%0d.data1", i), 32'(data1), 32'(vecs[i].d1));
            check($sformatf("v%0d.data2", i), 32'(data2), 32'(vecs[i].d2));
            check($sformatf("v%0d.data3", i), 32'(data3), 32'(vecs[i].d3));
            check($sformatf("v%0d.data4", i), 32'(data4), 32'(vecs[i].d4));
            check($sformatf("v%0d.data5", i), 32'(data5), 32'(vecs[i].d5));
            check($sformatf("v%0d.data6", i), 32'(data6), 32'(vecs[i].d6));
            check($sformatf("v%0d.data7", i), 32'(data7), 32'(vecs[i].d7));
            check($sformatf("v%0d.err_cnt", i), 32'(err_cnt), 32'(vecs[i].ec));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bz));
            check($sformatf("v%0d.upd_a_cycles", i), 32'(cnt_a - sa), 32'(vecs[i].pa));
            check($sformatf("v%0d.upd_b_cycles", i), 32'(cnt_b - sb), 32'(vecs[i].pb));
            check($sformatf("v%0d.upd_c_cycles", i), 32'(cnt_c - sc), 32'(vecs[i].pc));
            check($sformatf("v%0d.err_seq_cycles", i), 32'(cnt_s - ss), 32'(vecs[i].ps));
        end

        // Commit latency: first edge sampling cs high is edge 0, commit at edge 3
        send_word(16'd513);
        send_word(16'h1AAA);
        send_word(16'h2BBB);
        @(negedge clk) byte_from_eth = 16'h3CCC;
        @(negedge clk) cs = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            check($sformatf("lat.e%0d.upd_a", e), 32'(upd_a), 32'h0);
            check($sformatf("lat.e%0d.data1", e), 32'(data1), 32'h111);
        end
        @(posedge clk); #1;
        check("lat.e3.upd_a", 32'(upd_a), 32'h1);
        check_data("lat.e3", 16'hAAA, 16'hBBB, 16'hCCC, 16'hBEEF, 8'd4);
        @(posedge clk); #1;
        check("lat.e4.upd_a", 32'(upd_a), 32'h0);
        repeat (3) @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);

        // Timeout inside a frame
        send_word(16'd513);
        send_word(16'h1001);
        st = cnt_t;
        repeat (TMO - 100) @(negedge clk);
        check("tmo.early_busy", 32'(busy), 32'h1);
        check("tmo.early_pulse", 32'(cnt_t - st), 32'h0);
        n = 0;
        while (cnt_t == st && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("tmo.pulse_cycles", 32'(cnt_t - st), 32'h1);
        check("tmo.busy", 32'(busy), 32'h0);
        check_data("tmo", 16'hAAA, 16'hBBB, 16'hCCC, 16'hBEEF, 8'd5);
        send_word(16'd513);
        send_word(16'h1010);
        send_word(16'h2020);
        send_word(16'h3030);
        check_data("post_tmo", 16'h010, 16'h020, 16'h030, 16'hBEEF, 8'd5);

        // Reset mid-frame
        send_word(16'd513);
        send_word(16'h1AAA);
        send_word(16'h2BBB);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check_data("midrst", 16'h0, 16'h0, 16'd100, 16'd175, 8'd0);
        check("midrst.busy", 32'(busy), 32'h0);
        send_word(16'h3CCC);
        check_data("midrst.orphan", 16'h0, 16'h0, 16'd100, 16'd175, 8'd0);
        send_word(16'd513);
        send_word(16'h1001);
        send_word(16'h2002);
        send_word(16'h3003);
        check_data("midrst.frame", 16'h1, 16'h2, 16'h3, 16'd175, 8'd0);

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            send_word(16'd513);
            send_word(16'h0000);
        end
        check("sat.err_cnt", 32'(err_cnt), 32'hFF);
        check("sat.busy", 32'(busy), 32'h0);
        check("sat.data1", 32'(data1), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/can_frame_sequencer.md
Name: can_frame_sequencer

Overview:
- Clocked replacement and controller for the Ethernet-to-CAN word decoder.
- Synchronises the asynchronous `cs` word strobe into the system clock domain and sequences the 16-bit word stream through a frame state machine.
- Collects per-ID payload words into shadow registers and commits each group atomically.
- Flags protocol errors and timeouts for the vector-control register bank.

Parameters:
ID_A, 513, header word opening group A (data1..data3)
ID_B, 514, header word opening group B (data4..data6)
ID_C, 515, header word opening group C (data7, raw 16-bit)
ID_D, 520, header word opening reserved group D (one word consumed, discarded)
TIMEOUT_CYC, 50000, max clk cycles between strobes inside a frame
RST_DATA3, 100, reset value of data3
RST_DATA7, 175, reset value of data7

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cs  in  1  word strobe from Ethernet side, asynchronous to clk, rising edge = new word
byte_from_eth  in  16  word; stable from 1 clk before to 4 clk after cs rise
data1..data6  out  16 each  group A/B payloads, zero-extended from 12 bits
data7  out  16  group C raw word
upd_a, upd_b, upd_c  out  1 each  one-cycle pulse on group commit
err_seq  out  1  one-cycle pulse on sequence error
err_tmo  out  1  one-cycle pulse on timeout
err_cnt  out  8  saturating error count (err_seq + err_tmo)
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - data1 = data2 = data4 = data5 = data6 = 0; data3 = RST_DATA3; data7 = RST_DATA7.
  - All pulses 0; err_cnt = 0; state IDLE; shadows cleared; synchroniser flops cleared.
- Strobe:
  - cs passes through a 2-FF synchroniser, then an edge register; stb = sync2 & ~edge_q (one cycle).
  - byte_from_eth is registered on the stb cycle into word_q.
  - The FSM acts on word_q the cycle after stb.
  - Latency: the first clk edge sampling cs high is edge 0; outputs and pulses change at edge 3.
- Tag: word_q[13:12]; payload: word_q[11:0].
- States: IDLE, A1, A2, A3, B1, B2, B3, C1, D1.
- IDLE:
  - word == ID_A -> A1; ID_B -> B1; ID_C -> C1; ID_D -> D1.
  - Any other word: ignored, no error.
- Ax / Bx expect tags in strict order 1, 2, 3.
  - Matching tag: payload stored in shadow slot, advance to the next state.
  - At A3 / B3 with tag 3: all three shadows are copied to data1..3 / data4..6 in the same cycle; upd_a / upd_b pulses; -> IDLE.
- C1: next word -> data7 = full 16 bits, upd_c pulses, -> IDLE.
- D1: next word discarded, -> IDLE, no pulse.
- Header word precedence:
  - Inside A*/B*/C1, a word equal to ID_A..ID_D is treated as a header, not a payload.
  - It triggers err_seq, discards the shadows and enters the new group's first state (restart).
  - D1 consumes any word, including headers.
- Wrong tag inside A*/B* (including tag 0): err_seq pulses, shadows discarded, -> IDLE. data outputs unchanged.
- Timeout: tmo counter cleared on every stb; counts while busy. Reaching TIMEOUT_CYC -> err_tmo pulses, -> IDLE, shadows discarded.
- err_cnt: +1 per err_seq or err_tmo, saturates at 255. A simultaneous timeout and stb cannot occur because stb clears the counter first.
- Outputs: data outputs change only on commit, so a partial frame is never visible.
- Reset mid-frame: state IDLE, outputs return to reset values.

Test Plan:
- Words 513, 0x1ABC, 0x2123, 0x3456 -> data1 = 0x0ABC, data2 = 0x0123, data3 = 0x0456 all at once; upd_a one pulse at edge 3 after the last cs.
- Words 515, 0xBEEF -> data7 = 0xBEEF, upd_c pulse. Then 520, 0x1234 -> no output change, no pulse.
- Words 514, 0x1011, 0x3033 -> err_seq pulse, err_cnt = 1, data4..6 unchanged at 0, busy = 0.
- Words 513, 0x1001, 514, 0x1004, 0x2005, 0x3006 -> err_seq once, data4..6 = 4, 5, 6, upd_b pulse, data1..3 stay 0, 0, 100.
- Words 513, 0x1001, then no cs for TIMEOUT_CYC cycles -> err_tmo pulse, busy low, data1 = 0. Follow-up full A frame commits normally.
- Assert rst between the 2nd and 3rd payload of an A frame -> data3 = 100, data7 = 175, err_cnt = 0. Next full frame commits. Also run 300 bad frames -> err_cnt holds at 255.
